// File: rtl/tt_ternary_pkg.sv
// Shared types and sizing for the tiny ternary accelerator host transmitter.
// Bus widths here must match the accelerator top's ui_in/uio_in/uo_out.
package tt_ternary_pkg;

    localparam int IN_LEN  = 16;
    localparam int OUT_LEN = 8;
    localparam int WORD_W  = 16;
    localparam int RES_W   = 8;
    localparam int RES_LAT = 2;

    localparam logic [WORD_W-1:0] HDR_WORD = 16'h0001;

    // Each ternary weight is a 2-bit code, packed WORD_W bits per bus word.
    function automatic int calc_wwords(input int in_len, input int out_len, input int word_w);
        return (2 * in_len * out_len) / word_w;
    endfunction

    localparam int N_WWORDS = calc_wwords(IN_LEN, OUT_LEN, WORD_W);
    localparam int WADDR_W  = $clog2(N_WWORDS);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_ARST,
        ST_HDR,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/tt_ternary_wbuf.sv
// Weight buffer: holds one full weight matrix so LOAD can stream it without stalls.
// Contents are never cleared; only the write pointer is reset.
module tt_ternary_wbuf
    import tt_ternary_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic [WADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0]  rd_data,
    output logic [WADDR_W:0]   fill,
    output logic               full
);

    logic [WORD_W-1:0] mem [N_WWORDS];

    assign full    = (fill == (WADDR_W+1)'(N_WWORDS));
    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
        end else if (clr) begin
            fill <= '0;
        end else if (wr_en && !full) begin
            fill <= fill + (WADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[fill[WADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/tt_ternary_host_tx.sv
// Host-side transmitter: buffers weights, resets the accelerator, sends header + weights,
// then streams activations and returns tagged results from the accelerator output.
module tt_ternary_host_tx
    import tt_ternary_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [WORD_W-1:0] w_data,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [WORD_W-1:0] vec_data,
    input  logic              reload,
    output logic [WORD_W-1:0] bus_out,
    output logic              acc_rst_n,
    input  logic [RES_W-1:0]  bus_in,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_data,
    output logic              busy
);

    localparam int IDX_W = WADDR_W + 1;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   load_idx;
    logic [IDX_W-1:0]   load_idx_nxt;
    logic [WORD_W-1:0]  bus_nxt;
    logic [RES_LAT:0]   tag_sr;
    logic [IDX_W-1:0]   fill;
    logic [WORD_W-1:0]  rd_data;
    logic               full;
    logic               wr_en;
    logic               vec_acc;
    logic               fill_clr;

    // acc_rst_n is low only in reset and ARST, so it also keeps w_ready low until the first clock.
    assign w_ready   = (state == ST_FILL) && !full && acc_rst_n;
    assign wr_en     = w_valid && w_ready;
    assign vec_ready = (state == ST_RUN) && !reload;
    assign vec_acc   = vec_valid && vec_ready;
    assign busy      = (state != ST_FILL);
    assign fill_clr  = (state == ST_DRAIN) && (state_nxt == ST_FILL);

    tt_ternary_wbuf u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (fill_clr),
        .wr_en   (wr_en),
        .wr_data (w_data),
        .rd_addr (load_idx[WADDR_W-1:0]),
        .rd_data (rd_data),
        .fill    (fill),
        .full    (full)
    );

    // bus_nxt is the word shown on the bus in the cycle after this edge.
    always_comb begin
        state_nxt    = state;
        load_idx_nxt = load_idx;
        bus_nxt      = '0;
        unique case (state)
            ST_FILL: begin
                if (wr_en && fill == IDX_W'(N_WWORDS - 1)) state_nxt = ST_ARST;
            end
            ST_ARST: begin
                state_nxt = ST_HDR;
                bus_nxt   = HDR_WORD;
            end
            ST_HDR: begin
                state_nxt    = ST_LOAD;
                bus_nxt      = rd_data;
                load_idx_nxt = IDX_W'(1);
            end
            ST_LOAD: begin
                if (load_idx == IDX_W'(N_WWORDS)) begin
                    state_nxt    = ST_RUN;
                    load_idx_nxt = '0;
                end else begin
                    bus_nxt      = rd_data;
                    load_idx_nxt = load_idx + IDX_W'(1);
                end
            end
            ST_RUN: begin
                if (reload)       state_nxt = ST_DRAIN;
                else if (vec_acc) bus_nxt   = vec_data;
            end
            ST_DRAIN: begin
                // The oldest tag is consumed at this edge; leave once nothing younger remains.
                if (tag_sr[RES_LAT-1:0] == '0) state_nxt = ST_FILL;
            end
            default: begin
                state_nxt    = ST_FILL;
                load_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            load_idx  <= '0;
            bus_out   <= '0;
            acc_rst_n <= 1'b0;
            tag_sr    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_nxt;
            load_idx  <= load_idx_nxt;
            bus_out   <= bus_nxt;
            acc_rst_n <= (state_nxt != ST_ARST);
            tag_sr    <= {tag_sr[RES_LAT-1:0], vec_acc};
            res_valid <= tag_sr[RES_LAT];
            if (tag_sr[RES_LAT]) res_data <= bus_in;
        end
    end

endmodule

// File: tb/tb_tt_ternary_host_tx.sv
// Directed bench for tt_ternary_host_tx with a loopback accelerator model on bus_in.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tt_ternary_host_tx;

    logic        clk;
    logic        rst_n;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic        vec_valid;
    logic        vec_ready;
    logic [15:0] vec_data;
    logic        reload;
    logic [15:0] bus_out;
    logic        acc_rst_n;
    logic [7:0]  bus_in;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    tt_ternary_host_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .reload    (reload),
        .bus_out   (bus_out),
        .acc_rst_n (acc_rst_n),
        .bus_in    (bus_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accelerator stand-in: echoes the low byte of the bus two cycles later.
    logic [7:0] lb1, lb2;
    always @(posedge clk) begin
        lb1 <= bus_out[7:0];
        lb2 <= lb1;
    end
    assign bus_in = lb2;

    typedef struct {
        logic        vv;
        logic [15:0] vd;
        logic        rl;
        logic        exp_vr;
        logic [15:0] exp_bus;
        logic        exp_rv;
        logic [7:0]  exp_rd;
        logic        exp_busy;
        logic        exp_wr;
    } vec_t;

    vec_t tbl [9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic vv, input logic [15:0] vd, input logic rl);
        vec_valid = vv;
        vec_data  = vd;
        reload    = rl;
    endtask

    task automatic check_reset_values();
        check_output("rst_bus_out",   bus_out,   0);
        check_output("rst_acc_rst_n", acc_rst_n, 0);
        check_output("rst_res_valid", res_valid, 0);
        check_output("rst_res_data",  res_data,  0);
        check_output("rst_w_ready",   w_ready,   0);
        check_output("rst_vec_ready", vec_ready, 0);
        check_output("rst_busy",      busy,      0);
    endtask

    // Fill 16 words with random gaps, then check ARST, header and the load burst.
    // abort_k >= 0 pulses rst_n after load word abort_k is seen.
    task automatic fill_and_load(input logic [15:0] base, input int abort_k);
        int k = 0;
        int guard = 0;
        while (k < 16 && guard < 400) begin
            w_valid = ($urandom_range(0, 2) != 0);
            w_data  = base + 16'(k);
            #1 check_output("fill_w_ready", w_ready, 1);
            @(negedge clk);
            guard++;
            if (w_valid) k++;
        end
        if (k < 16) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL fill_timeout: got %0d words expected 16", k);
        end
        w_valid = 1'b1;
        w_data  = 16'hDEAD;
        check_output("arst_acc_rst_n", acc_rst_n, 0);
        check_output("arst_bus_out",   bus_out,   0);
        check_output("arst_busy",      busy,      1);
        #1 check_output("arst_w_ready", w_ready, 0);
        @(negedge clk);
        check_output("hdr_bus_out",   bus_out,   16'h0001);
        check_output("hdr_acc_rst_n", acc_rst_n, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_output("load_bus_out", bus_out, base + 16'(i));
            check_output("load_w_ready", w_ready, 0);
            if (i == abort_k) begin
                rst_n   = 1'b0;
                w_valid = 1'b0;
                #1 check_reset_values();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_output("rerst_acc_rst_n", acc_rst_n, 1);
                check_output("rerst_w_ready",   w_ready,   1);
                check_output("rerst_bus_out",   bus_out,   0);
                return;
            end
        end
        w_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // vv, vd, rl | vec_ready, bus_out, res_valid, res_data, busy, w_ready (after the edge)
        tbl[0] = '{1'b1, 16'h00A5, 1'b0, 1'b1, 16'h00A5, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 16'h003C, 1'b0, 1'b1, 16'h003C, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 16'h0011, 1'b0, 1'b1, 16'h0011, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'h0022, 1'b0, 1'b1, 16'h0022, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 16'h0033, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 16'h0044, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h22, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 16'h0055, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1};

        rst_n     = 1'b0;
        w_valid   = 1'b0;
        w_data    = '0;
        vec_valid = 1'b0;
        vec_data  = '0;
        reload    = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        #1 check_output("release_acc_rst_n_low", acc_rst_n, 0);
        @(negedge clk);
        check_output("release_acc_rst_n", acc_rst_n, 1);
        check_output("release_bus_out",   bus_out,   0);
        check_output("release_w_ready",   w_ready,   1);
        check_output("release_busy",      busy,      0);

        fill_and_load(16'h1000, -1);

        @(negedge clk);
        check_output("run_entry_bus_out", bus_out, 0);
        check_output("run_entry_busy",    busy,    1);

        for (int r = 0; r < 9; r++) begin
            apply_stimulus(tbl[r].vv, tbl[r].vd, tbl[r].rl);
            #1 check_output("tbl_vec_ready", vec_ready, tbl[r].exp_vr);
            @(negedge clk);
            check_output("tbl_bus_out",   bus_out,   tbl[r].exp_bus);
            check_output("tbl_res_valid", res_valid, tbl[r].exp_rv);
            if (tbl[r].exp_rv) check_output("tbl_res_data", res_data, tbl[r].exp_rd);
            check_output("tbl_busy",      busy,      tbl[r].exp_busy);
            check_output("tbl_w_ready",   w_ready,   tbl[r].exp_wr);
        end
        apply_stimulus(1'b0, 16'h0000, 1'b0);

        fill_and_load(16'h2000, 7);
        fill_and_load(16'h3000, -1);

        @(negedge clk);
        check_output("rerun_bus_out", bus_out, 0);
        check_output("rerun_busy",    busy,    1);
        apply_stimulus(1'b1, 16'h0077, 1'b0);
        #1 check_output("rerun_vec_ready", vec_ready, 1);
        @(negedge clk);
        check_output("rerun_first_word", bus_out, 16'h0077);
        apply_stimulus(1'b0, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
